// File: rtl/screen_ram_reader_if.sv
// screen_ram_reader_if
//   Bundles the signals between the screen RAM reader, the RAM read/write
//   port and the downstream pixel consumer.
//   Signals:
//     enable     run scanning (from control logic)
//     ram_addr   word address presented to the RAM port
//     ram_write  write strobe to the RAM port (reader never writes)
//     ram_wdata  write data to the RAM port (always zero)
//     ram_rdata  read data from the RAM, one cycle after the address is sampled
//     pix_valid  pixel available
//     pix_ready  consumer accepts the pixel
//     pix_data   pixel value, 1 = black
//     pix_sof    pixel is row 0, col 0 of a frame
//     pix_eol    pixel is the last pixel of a row
//   Modports: master = the reader, slave = RAM/consumer side.
interface screen_ram_reader_if #(
  parameter int DW = 16,
  parameter int AW = 13
);
  logic          enable;
  logic [AW-1:0] ram_addr;
  logic          ram_write;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_data;
  logic          pix_sof;
  logic          pix_eol;

  modport master (
    input  enable, ram_rdata, pix_ready,
    output ram_addr, ram_write, ram_wdata,
    output pix_valid, pix_data, pix_sof, pix_eol
  );

  modport slave (
    output enable, ram_rdata, pix_ready,
    input  ram_addr, ram_write, ram_wdata,
    input  pix_valid, pix_data, pix_sof, pix_eol
  );
endinterface

// File: rtl/screen_ram_reader.sv
// screen_ram_reader
//   Scans the Hack screen memory map word by word through a RAM port and
//   serialises each word into a 1-bit pixel stream with start-of-frame and
//   end-of-line markers. The consumer drains pixels with valid/ready.
//   Ports:
//     clk  clock
//     rst  asynchronous, active-high reset
//     bus  screen_ram_reader_if.master (RAM port + pixel stream + enable)
//   Parameters: DW pixels per word, AW address width, BASE word address of
//   pixel (0,0), WORDS_PER_ROW and ROWS give the frame geometry.
module screen_ram_reader #(
  parameter int DW            = 16,
  parameter int AW            = 13,
  parameter int BASE          = 0,
  parameter int WORDS_PER_ROW = 32,
  parameter int ROWS          = 256
) (
  input logic                 clk,
  input logic                 rst,
  screen_ram_reader_if.master bus
);

  localparam int WORDS = WORDS_PER_ROW * ROWS;
  localparam int FW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int BW    = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [AW-1:0] BASE_A    = AW'(BASE);
  localparam logic [FW-1:0] LAST_WORD = FW'(WORDS - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(WORDS_PER_ROW - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [FW-1:0] fetch_idx;
  logic [CW-1:0] fetch_col;

  // Two-stage read tracker: rd_pend = address just issued (RAM samples it
  // next edge), rd_ret = read data is on ram_rdata this cycle.
  logic          rd_pend;
  logic          rd_ret;
  logic          pend_sof;
  logic          pend_eol;

  logic [DW-1:0] shift_word;
  logic          shift_full;
  logic          shift_sof;
  logic          shift_eol;
  logic [BW-1:0] bit_idx;

  logic [DW-1:0] buf_word;
  logic          buf_full;
  logic          buf_sof;
  logic          buf_eol;

  logic accept;
  logic last_bit;
  logic in_flight;
  logic start;
  logic issue;
  logic frame_end;

  assign accept    = shift_full & bus.pix_ready;
  assign last_bit  = accept & (bit_idx == LAST_BIT);
  assign in_flight = rd_pend | rd_ret;
  assign start     = (state == IDLE) & bus.enable;
  assign frame_end = (fetch_idx == LAST_WORD);

  // With at most one read outstanding and the buffer only ever filled by a
  // returning read, an empty buffer now guarantees a landing slot later.
  assign issue = ~in_flight & ~buf_full & (start | (state == RUN));

  assign bus.ram_addr  = addr_q;
  assign bus.ram_write = 1'b0;
  assign bus.ram_wdata = '0;
  assign bus.pix_valid = shift_full;
  assign bus.pix_data  = shift_full & shift_word[bit_idx];
  assign bus.pix_sof   = shift_full & shift_sof & (bit_idx == '0);
  assign bus.pix_eol   = shift_full & shift_eol & (bit_idx == LAST_BIT);

  // Scan state machine, fetch sequencer and the shift register / one-word
  // buffer pair. Word markers are captured at issue time and travel with the
  // word, so they stay correct however far the fetch side runs ahead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      fetch_idx  <= '0;
      fetch_col  <= '0;
      rd_pend    <= 1'b0;
      rd_ret     <= 1'b0;
      pend_sof   <= 1'b0;
      pend_eol   <= 1'b0;
      shift_word <= '0;
      shift_full <= 1'b0;
      shift_sof  <= 1'b0;
      shift_eol  <= 1'b0;
      bit_idx    <= '0;
      buf_word   <= '0;
      buf_full   <= 1'b0;
      buf_sof    <= 1'b0;
      buf_eol    <= 1'b0;
    end else begin
      rd_pend <= issue;
      rd_ret  <= rd_pend;

      if (issue) begin
        addr_q    <= BASE_A + AW'(fetch_idx);
        pend_sof  <= (fetch_idx == '0);
        pend_eol  <= (fetch_col == LAST_COL);
        fetch_idx <= frame_end ? '0 : fetch_idx + FW'(1);
        fetch_col <= (fetch_col == LAST_COL) ? '0 : fetch_col + CW'(1);
      end

      // enable only matters in IDLE and at the last fetch of a frame, so a
      // frame that has started always completes.
      unique case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (issue && frame_end && !bus.enable) state <= DRAIN;
        DRAIN:   if (!shift_full && !buf_full && !in_flight) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (accept) begin
        bit_idx <= last_bit ? '0 : bit_idx + BW'(1);
      end

      // Returning data refills the shift register directly when it is empty
      // or draining its last bit, which keeps pix_valid free of bubbles.
      if (rd_ret) begin
        if (!shift_full || last_bit) begin
          shift_word <= bus.ram_rdata;
          shift_full <= 1'b1;
          shift_sof  <= pend_sof;
          shift_eol  <= pend_eol;
        end else begin
          buf_word <= bus.ram_rdata;
          buf_full <= 1'b1;
          buf_sof  <= pend_sof;
          buf_eol  <= pend_eol;
        end
      end else if (last_bit) begin
        if (buf_full) begin
          shift_word <= buf_word;
          shift_sof  <= buf_sof;
          shift_eol  <= buf_eol;
          buf_full   <= 1'b0;
        end else begin
          shift_full <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_screen_ram_reader.sv
// tb_screen_ram_reader
//   Self-checking bench for screen_ram_reader with a small 2x2-word frame at
//   BASE=4. A synchronous RAM model feeds the DUT; the expected pixel stream
//   of each frame is built from the RAM contents with plain arithmetic and
//   compared on every accepted pixel. The compare process also watches the
//   address sequence, read spacing, stall stability and bubble-free output.
module tb_screen_ram_reader;

  localparam int DW       = 16;
  localparam int AW       = 13;
  localparam int BASE     = 4;
  localparam int WPR      = 2;
  localparam int ROWS     = 2;
  localparam int WORDS    = WPR * ROWS;
  localparam int FRAME_PX = WORDS * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  screen_ram_reader_if #(.DW(DW), .AW(AW)) bus ();

  screen_ram_reader #(
    .DW(DW), .AW(AW), .BASE(BASE), .WORDS_PER_ROW(WPR), .ROWS(ROWS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] mem [0:15];

  // Synchronous read RAM: data appears the cycle after the address is sampled.
  always @(posedge clk) bus.ram_rdata <= mem[bus.ram_addr[3:0]];

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0]    expq [$];
  logic [2:0]    got;
  logic [2:0]    exp_px;
  logic [2:0]    prev_out;
  logic [AW-1:0] prev_addr;
  int            pix_cnt    = 0;
  int            addr_idx   = 0;
  int            gap        = 99;
  int            start_cnt  = 0;
  bit            rand_ready = 1'b0;
  bit            gapless    = 1'b0;
  bit            seen_valid = 1'b0;
  bit            prev_stall = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  name, actual, expected, $time);
  endtask

  // Expected frame: pixel p lives in word p/DW at bit p%DW; packed as
  // {data, sof, eol}.
  function automatic void pushFrame();
    int w;
    int b;
    logic [DW-1:0] word;
    for (int p = 0; p < FRAME_PX; p++) begin
      w    = p / DW;
      b    = p % DW;
      word = mem[BASE + w];
      expq.push_back({word[b], (p == 0), ((w % WPR) == WPR - 1) && (b == DW - 1)});
    end
  endfunction

  // Ready generator: held high, or random when rand_ready is set.
  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      seen_valid = 1'b0;
      addr_idx   = 0;
      gap        = 99;
      prev_addr  = bus.ram_addr;
    end else begin
      got = {bus.pix_data, bus.pix_sof, bus.pix_eol};
      checkOutput("ram_write_zero", {bus.ram_write, bus.ram_wdata}, 0);
      if (prev_stall)
        checkOutput("stall_hold", {bus.pix_valid, got}, {1'b1, prev_out});
      if (gapless && seen_valid && expq.size() > 0)
        checkOutput("no_bubble", bus.pix_valid, 1);
      gap++;
      if (bus.ram_addr != prev_addr) begin
        checkOutput("addr_seq", bus.ram_addr, BASE + (addr_idx % WORDS));
        checkOutput("one_in_flight", gap >= 2, 1);
        addr_idx++;
        gap       = 0;
        prev_addr = bus.ram_addr;
      end
      if (bus.pix_valid) seen_valid = 1'b1;
      if (bus.pix_valid && bus.pix_ready) begin
        pix_cnt++;
        if (expq.size() == 0) begin
          checkOutput("extra_pixel", 1, 0);
        end else begin
          exp_px = expq.pop_front();
          checkOutput("pixel", got, exp_px);
          if (expq.size() == 0) seen_valid = 1'b0;
        end
      end
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev_out   = got;
    end
  end

  task automatic waitPixels(input int target);
    int budget = 3000;
    while (pix_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (pix_cnt < target) checkOutput("pixel_timeout", pix_cnt, target);
  endtask

  task automatic waitDrained();
    int budget = 3000;
    while ((expq.size() != 0 || bus.pix_valid) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checkOutput("drain_timeout", expq.size(), 0);
      expq.delete();
    end
    repeat (30) @(negedge clk);
    checkOutput("idle_valid", bus.pix_valid, 0);
    checkOutput("addr_hold", bus.ram_addr, BASE + WORDS - 1);
  endtask

  // Queue nframes of expected pixels, raise enable, optionally check the
  // start-up latency (preloaded RAM only), then drop enable at pixel drop_at.
  task automatic applyStimulus(input int nframes, input bit rnd,
                               input int drop_at, input bit check_latency);
    for (int f = 0; f < nframes; f++) pushFrame();
    rand_ready = rnd;
    gapless    = !rnd;
    start_cnt  = pix_cnt;
    @(posedge clk);
    #1;
    bus.enable = 1'b1;
    if (check_latency) begin
      @(negedge clk);
      @(negedge clk);
      checkOutput("lat_addr_issue", bus.ram_addr, BASE);
      @(negedge clk);
      checkOutput("lat_valid_low", bus.pix_valid, 0);
      @(negedge clk);
      checkOutput("lat_first_pixel", {bus.pix_valid, bus.pix_sof, bus.pix_data}, 3'b111);
      checkOutput("lat_first_addr", bus.ram_addr, BASE);
    end
    if (drop_at >= 0) begin
      waitPixels(start_cnt + drop_at);
      bus.enable = 1'b0;
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[4] = 16'h0001;
    mem[5] = 16'h8000;
    mem[6] = 16'hFFFF;
    mem[7] = 16'h0000;

    // Hand-computed frame for the preloaded RAM.
    pushFrame();
    checkOutput("model_px0", expq[0], 3'b110);
    checkOutput("model_px1", expq[1], 3'b000);
    checkOutput("model_px31", expq[31], 3'b101);
    checkOutput("model_px32", expq[32], 3'b100);
    checkOutput("model_px47", expq[47], 3'b100);
    checkOutput("model_px48", expq[48], 3'b000);
    checkOutput("model_px63", expq[63], 3'b001);
    expq.delete();

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_outputs", {bus.ram_addr, bus.pix_valid, bus.pix_data,
                                  bus.pix_sof, bus.pix_eol, bus.ram_write}, 0);

    $display("[TB] single frame, ready held high");
    applyStimulus(1, 1'b0, 10, 1'b1);
    waitDrained();

    $display("[TB] single frame, random ready, enable dropped early");
    applyStimulus(1, 1'b1, 10, 1'b0);
    waitDrained();

    $display("[TB] two frames back to back, ready held high");
    applyStimulus(2, 1'b0, 70, 1'b1);
    waitDrained();

    $display("[TB] reset mid-frame then restart");
    applyStimulus(1, 1'b1, -1, 1'b0);
    waitPixels(start_cnt + 20);
    @(posedge clk);
    #2;
    rst        = 1'b1;
    bus.enable = 1'b0;
    #1;
    checkOutput("reset_midframe", {bus.pix_valid, bus.pix_data,
                                   bus.pix_sof, bus.pix_eol}, 0);
    expq.delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1, 1'b0, 10, 1'b1);
    waitDrained();

    $display("[TB] random RAM contents, random ready, two frames");
    for (int i = BASE; i < BASE + WORDS; i++) mem[i] = 16'($urandom);
    applyStimulus(2, 1'b1, 70, 1'b0);
    waitDrained();

    $display("[TB] random RAM contents, ready held high");
    for (int i = BASE; i < BASE + WORDS; i++) mem[i] = 16'($urandom);
    applyStimulus(1, 1'b0, 10, 1'b0);
    waitDrained();

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
